rvv_backend_dispatch_credit_ctrl: RTL and testbench
===================================================

# rvv_backend_dispatch_credit_ctrl

Credit-based dispatch controller between the Uop Queue head and the reservation stations (RS). Each cycle it examines up to `NUM_DP` head uops and pops them strictly in order. A uop is popped only when its target RS has a free entry, as tracked by one credit counter per RS. It also steers each popped uop to its RS, and reports stalls and credit-protocol violations.

## Interface
Parameters:
- `NUM_DP`, 2, head uops examined per cycle
- `NUM_RS`, 4, number of reservation stations (0=ALU, 1=MUL, 2=PMT, 3=LSU)
- `RS_DEPTH`, 8, entries per RS; this is also the credit reset value
- `RS_SEL_W`, `$clog2(NUM_RS)`, width of RS selector
- `CNT_W`, `$clog2(RS_DEPTH+1)`, credit counter width

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `uq_valid`  in  [NUM_DP-1:0]  head uop i valid
- `uq_rs_sel`  in  [NUM_DP-1:0][RS_SEL_W-1:0]  target RS of head uop i
- `trap_flush`  in  1  suppresses all pops this cycle
- `credit_ret`  in  [NUM_RS-1:0]  RS r freed one entry (at most one per RS per cycle)
- `uq_pop`  out  [NUM_DP-1:0]  head uop i dispatched this cycle
- `rs_push`  out  [NUM_RS-1:0][NUM_DP-1:0]  one-hot steering: uop i written to RS r
- `credit_cnt`  out  [NUM_RS-1:0][CNT_W-1:0]  registered credit counts
- `dp_stall`  out  1  `uq_valid[0] & !uq_pop[0]`
- `credit_err`  out  1  sticky credit-overflow flag

## Operation
- Available credit per RS: `avail[r] = credit_cnt[r]`. With the bypass feature, `avail[r] = credit_cnt[r] + credit_ret[r]` (see Configuration).
- Grant rule: `uq_pop[i]` is 1 iff all of the following hold:
  - `uq_valid[i]`
  - `!trap_flush`
  - `uq_pop[j]` for all j<i
  - `avail[uq_rs_sel[i]]` is greater than the number of pops j<i targeting the same RS
- Slots are handled strictly in order. A blocked slot blocks every later slot, even when a later slot's RS has credit.
- A valid slot after an invalid slot is never popped.
- `rs_push[r][i] = uq_pop[i] & (uq_rs_sel[i]==r)`. This path is purely combinational from the inputs and registered counts.
- `uq_rs_sel >= NUM_RS`: the slot is treated as blocked and is never popped.
- Counter update per RS: `next = credit_cnt - grants[r] + credit_ret[r]`, where `grants[r]` is the number of pops to r this cycle.
- Overflow: if `credit_cnt[r]==RS_DEPTH`, `credit_ret[r]=1` and `grants[r]==0`, then:
  - the counter holds at RS_DEPTH;
  - `credit_err` sets and stays set until reset.
- Underflow cannot occur by construction; the grant rule guarantees `grants[r] <= avail[r]`.
- `trap_flush` does not affect credit returns; counters still increment.

## Timing
- Reset values:
  - `credit_cnt[r] = RS_DEPTH` for all r
  - `credit_err = 0`
  - `uq_pop`, `rs_push` and `dp_stall` evaluate to 0 when all inputs are 0
- Pop decision latency is 0 cycles. `uq_pop` is combinational in the same cycle as `uq_valid`. The Uop Queue advances its head at the same clock edge.
- Credit consumption is visible in `credit_cnt` one cycle after the pop.
- Credit return is usable for grants:
  - without bypass, the cycle after `credit_ret`;
  - with bypass, the same cycle.
- Reset asserted mid-operation:
  - counters return to RS_DEPTH asynchronously;
  - any in-flight RS contents are the owner's responsibility (the RS is reset together).
- No internal FSM beyond the per-RS counters and the sticky error bit. Throughput is up to `NUM_DP` uops per cycle.

## Configuration
- Macro: `RVV_DP_CREDIT_BYPASS_EN`.
- Defined: a credit returned in cycle t may be granted in cycle t. `avail` includes `credit_ret`, and the overflow check still uses the registered count.
- Undefined: a returned credit is usable from cycle t+1 only. This removes the `credit_ret`→`uq_pop` combinational path.

## Test plan
- Reset, then idle 3 cycles -> every `credit_cnt`=8, `credit_err`=0, `uq_pop`=0, `dp_stall`=0.
- Both slots valid targeting ALU for 5 consecutive cycles, no returns -> pop pattern 11,11,11,11,00; `credit_cnt[0]` goes 8,6,4,2,0,0; `dp_stall`=1 in cycle 5.
- `credit_cnt[1]`=1, both slots target MUL -> `uq_pop`=01, `rs_push[1]`=01, count becomes 0 next cycle.
- Slot0 targets LSU with 0 credits, slot1 targets ALU with 8 credits -> `uq_pop`=00, `dp_stall`=1, ALU count unchanged.
- LSU count 0, slot0 targets LSU, `credit_ret[3]`=1 in the same cycle:
  - with bypass: pop in that cycle, count stays 0;
  - without bypass: pop the next cycle, count 1 then 0.
- ALU count 8, `credit_ret[0]`=1, no pops -> count stays 8, `credit_err`=1 and remains 1 until `rst`. Also: `trap_flush`=1 with valid uops -> `uq_pop`=00.

Source files
------------

// File: rtl/rvv_backend_dispatch_credit_ctrl.sv
// Credit-based in-order dispatch from the Uop Queue head to the reservation stations.
// Optional same-cycle credit bypass: define RVV_DP_CREDIT_BYPASS_EN.
module rvv_backend_dispatch_credit_ctrl #(
  parameter int NUM_DP   = 2,
  parameter int NUM_RS   = 4,
  parameter int RS_DEPTH = 8,
  parameter int RS_SEL_W = $clog2(NUM_RS),
  parameter int CNT_W    = $clog2(RS_DEPTH + 1)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_DP-1:0]                  uq_valid,
  input  logic [NUM_DP-1:0][RS_SEL_W-1:0]    uq_rs_sel,
  input  logic                               trap_flush,
  input  logic [NUM_RS-1:0]                  credit_ret,
  output logic [NUM_DP-1:0]                  uq_pop,
  output logic [NUM_RS-1:0][NUM_DP-1:0]      rs_push,
  output logic [NUM_RS-1:0][CNT_W-1:0]       credit_cnt,
  output logic                               dp_stall,
  output logic                               credit_err
);

  logic [NUM_RS-1:0][CNT_W-1:0] r_cnt;
  logic                         r_err;

  logic [NUM_RS-1:0][CNT_W:0]   w_avail;
  logic [NUM_RS-1:0][CNT_W:0]   w_grants;
  logic [NUM_RS-1:0][CNT_W-1:0] w_cnt_nxt;
  logic [NUM_RS-1:0]            w_ovf;

  always_comb begin
    for (int r = 0; r < NUM_RS; r++) begin
`ifdef RVV_DP_CREDIT_BYPASS_EN
      w_avail[r] = {1'b0, r_cnt[r]} + (CNT_W+1)'(credit_ret[r]);
`else
      w_avail[r] = {1'b0, r_cnt[r]};
`endif
    end
  end

  // In-order grant: the first slot that cannot go stops every later slot.
  // A selector matching no RS never produces a hit, so it blocks.
  always_comb begin : grant
    logic                       w_chain;
    logic                       w_hit;
    logic [NUM_RS-1:0][CNT_W:0] w_used;
    uq_pop  = '0;
    rs_push = '0;
    w_used  = '0;
    w_chain = !trap_flush;
    w_hit   = 1'b0;
    for (int i = 0; i < NUM_DP; i++) begin
      w_hit = 1'b0;
      for (int r = 0; r < NUM_RS; r++) begin
        if (uq_rs_sel[i] == RS_SEL_W'(r) && w_avail[r] > w_used[r]) w_hit = 1'b1;
      end
      if (w_chain && uq_valid[i] && w_hit) begin
        uq_pop[i] = 1'b1;
        for (int r = 0; r < NUM_RS; r++) begin
          if (uq_rs_sel[i] == RS_SEL_W'(r)) begin
            rs_push[r][i] = 1'b1;
            w_used[r]     = w_used[r] + (CNT_W+1)'(1);
          end
        end
      end else begin
        w_chain = 1'b0;
      end
    end
    w_grants = w_used;
  end

  // A return into a full, unconsumed RS is a protocol violation: hold and flag.
  always_comb begin : cnt_next
    logic [CNT_W:0] w_sum;
    w_sum     = '0;
    w_cnt_nxt = r_cnt;
    w_ovf     = '0;
    for (int r = 0; r < NUM_RS; r++) begin
      w_sum    = {1'b0, r_cnt[r]} - w_grants[r] + (CNT_W+1)'(credit_ret[r]);
      w_ovf[r] = (r_cnt[r] == CNT_W'(RS_DEPTH)) && credit_ret[r] && (w_grants[r] == '0);
      w_cnt_nxt[r] = w_ovf[r] ? r_cnt[r] : w_sum[CNT_W-1:0];
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_RS; r++) r_cnt[r] <= CNT_W'(RS_DEPTH);
      r_err <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (|w_ovf) r_err <= 1'b1;
    end
  end

  assign credit_cnt = r_cnt;
  assign credit_err = r_err;
  assign dp_stall   = uq_valid[0] & ~uq_pop[0];

endmodule

// File: tb/tb_rvv_backend_dispatch_credit_ctrl.sv
// Directed scoreboard bench for rvv_backend_dispatch_credit_ctrl (NUM_DP=2, NUM_RS=4, RS_DEPTH=8).
module tb_rvv_backend_dispatch_credit_ctrl;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      uq_valid;
  logic [1:0][1:0] uq_rs_sel;
  logic            trap_flush;
  logic [3:0]      credit_ret;
  logic [1:0]      uq_pop;
  logic [3:0][1:0] rs_push;
  logic [3:0][3:0] credit_cnt;
  logic            dp_stall;
  logic            credit_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [1:0]  pop;
    logic [7:0]  push;
    logic        stall;
    logic [15:0] cnt;
    logic        err;
  } exp_t;

  exp_t sb_q[$];

  rvv_backend_dispatch_credit_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .uq_valid   (uq_valid),
    .uq_rs_sel  (uq_rs_sel),
    .trap_flush (trap_flush),
    .credit_ret (credit_ret),
    .uq_pop     (uq_pop),
    .rs_push    (rs_push),
    .credit_cnt (credit_cnt),
    .dp_stall   (dp_stall),
    .credit_err (credit_err)
  );

  always #5 clk = ~clk;

  initial begin
    #20000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [15:0] cnts(int a, int m, int p, int l);
    return {4'(l), 4'(p), 4'(m), 4'(a)};
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare();
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard: observed=empty expected=entry");
    end else begin
      e = sb_q.pop_front();
      check({e.tag, ".pop"},   32'(uq_pop),     32'(e.pop));
      check({e.tag, ".push"},  32'(rs_push),    32'(e.push));
      check({e.tag, ".stall"}, 32'(dp_stall),   32'(e.stall));
      check({e.tag, ".cnt"},   32'(credit_cnt), 32'(e.cnt));
      check({e.tag, ".err"},   32'(credit_err), 32'(e.err));
    end
  endtask

  // Drive one cycle of stimulus away from the rising edge, queue its expectation, then compare.
  task automatic step(string tag, logic [1:0] v, logic [1:0] s0, logic [1:0] s1,
                      logic fl, logic [3:0] ret, logic [1:0] e_pop, logic [7:0] e_push,
                      logic [15:0] e_cnt, logic e_err);
    exp_t e;
    @(negedge clk);
    uq_valid     = v;
    uq_rs_sel[0] = s0;
    uq_rs_sel[1] = s1;
    trap_flush   = fl;
    credit_ret   = ret;
    e.tag   = tag;
    e.pop   = e_pop;
    e.push  = e_push;
    e.stall = v[0] & ~e_pop[0];
    e.cnt   = e_cnt;
    e.err   = e_err;
    sb_q.push_back(e);
    #1;
    compare();
  endtask

  task automatic idle(string tag, logic [3:0] ret, logic [15:0] e_cnt, logic e_err);
    step(tag, 2'b00, 2'd0, 2'd0, 1'b0, ret, 2'b00, 8'h00, e_cnt, e_err);
  endtask

  initial begin
    rst        = 1'b1;
    uq_valid   = '0;
    uq_rs_sel  = '0;
    trap_flush = 1'b0;
    credit_ret = '0;
    repeat (2) @(negedge clk);
    idle("in_reset", 4'b0000, cnts(8, 8, 8, 8), 1'b0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) idle("idle", 4'b0000, cnts(8, 8, 8, 8), 1'b0);

    // ALU drain: two pops per cycle until empty
    for (int k = 0; k < 4; k++)
      step("alu_drain", 2'b11, 2'd0, 2'd0, 1'b0, 4'b0000, 2'b11, 8'h03, cnts(8 - 2*k, 8, 8, 8), 1'b0);
    step("alu_empty", 2'b11, 2'd0, 2'd0, 1'b0, 4'b0000, 2'b00, 8'h00, cnts(0, 8, 8, 8), 1'b0);
    idle("alu_hold", 4'b0000, cnts(0, 8, 8, 8), 1'b0);

    // MUL down to one credit, then two requests with one credit
    for (int k = 0; k < 3; k++)
      step("mul_drain", 2'b11, 2'd1, 2'd1, 1'b0, 4'b0000, 2'b11, 8'h0C, cnts(0, 8 - 2*k, 8, 8), 1'b0);
    step("mul_one", 2'b01, 2'd1, 2'd1, 1'b0, 4'b0000, 2'b01, 8'h04, cnts(0, 2, 8, 8), 1'b0);
    step("mul_last", 2'b11, 2'd1, 2'd1, 1'b0, 4'b0000, 2'b01, 8'h04, cnts(0, 1, 8, 8), 1'b0);
    idle("mul_zero", 4'b0000, cnts(0, 0, 8, 8), 1'b0);

    step("slot0_invalid", 2'b10, 2'd0, 2'd2, 1'b0, 4'b0000, 2'b00, 8'h00, cnts(0, 0, 8, 8), 1'b0);

    // Drain LSU while refilling ALU via returns
    for (int k = 0; k < 4; k++)
      step("lsu_drain", 2'b11, 2'd3, 2'd3, 1'b0, 4'b0001, 2'b11, 8'hC0, cnts(k, 0, 8, 8 - 2*k), 1'b0);
    for (int k = 0; k < 4; k++)
      idle("alu_refill", 4'b0001, cnts(4 + k, 0, 8, 0), 1'b0);

    step("in_order_block", 2'b11, 2'd3, 2'd0, 1'b0, 4'b0000, 2'b00, 8'h00, cnts(8, 0, 8, 0), 1'b0);
    idle("alu_unchanged", 4'b0000, cnts(8, 0, 8, 0), 1'b0);

`ifdef RVV_DP_CREDIT_BYPASS_EN
    step("ret_bypass", 2'b01, 2'd3, 2'd0, 1'b0, 4'b1000, 2'b01, 8'h40, cnts(8, 0, 8, 0), 1'b0);
    idle("ret_bypass_after", 4'b0000, cnts(8, 0, 8, 0), 1'b0);
`else
    step("ret_nobypass", 2'b01, 2'd3, 2'd0, 1'b0, 4'b1000, 2'b00, 8'h00, cnts(8, 0, 8, 0), 1'b0);
    step("ret_next_cycle", 2'b01, 2'd3, 2'd0, 1'b0, 4'b0000, 2'b01, 8'h40, cnts(8, 0, 8, 1), 1'b0);
    idle("ret_after", 4'b0000, cnts(8, 0, 8, 0), 1'b0);
`endif

    idle("ovf_cycle", 4'b0001, cnts(8, 0, 8, 0), 1'b0);
    idle("ovf_sticky", 4'b0000, cnts(8, 0, 8, 0), 1'b1);

    step("flush", 2'b11, 2'd0, 2'd0, 1'b1, 4'b0010, 2'b00, 8'h00, cnts(8, 0, 8, 0), 1'b1);
    idle("flush_ret", 4'b0000, cnts(8, 1, 8, 0), 1'b1);

    rst = 1'b1;
    idle("mid_reset", 4'b0000, cnts(8, 8, 8, 8), 1'b0);
    rst = 1'b0;
    idle("post_reset", 4'b0000, cnts(8, 8, 8, 8), 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
